// File: rtl/slice_add_sequencer.sv
// Serialises a WIDTH-bit add onto an external SLICE-bit adder, LSB slice first,
// chaining the carry between slices and returning the full result over valid/ready.
module slice_add_sequencer #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [SLICE-1:0] add_a,
    output logic [SLICE-1:0] add_b,
    output logic             add_cin,
    input  logic [SLICE-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [SLICE-1:0] a_slice [NSLICE];
    logic [SLICE-1:0] b_slice [NSLICE];

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_slice[gi] = a_q[gi*SLICE +: SLICE];
            assign b_slice[gi] = b_q[gi*SLICE +: SLICE];
        end
    endgenerate

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

    // The adder only ever sees operand bits while a slice is actually being computed.
    assign add_a   = (state_q == RUN) ? a_slice[idx_q] : '0;
    assign add_b   = (state_q == RUN) ? b_slice[idx_q] : '0;
    assign add_cin = (state_q == RUN) ? carry_q : 1'b0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int s = 0; s < NSLICE; s++) begin
                    if (idx_q == IW'(s)) begin
                        sum_d[s*SLICE +: SLICE] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    // Index parks at zero rather than stepping past the last slice.
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end
endmodule

// File: tb/tb_slice_add_sequencer.sv
// Directed bench for slice_add_sequencer with a behavioural 4-bit adder on the slice port.
module tb_slice_add_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        in_cin;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        out_valid, out_ready;
    logic [15:0] out_sum;
    logic        out_cout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    slice_add_sequencer #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Full transaction with out_ready already high; returns add_a / add_cin as seen per RUN cycle.
    task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [15:0] exp_sum, input logic exp_cout,
                           output logic [15:0] a_seq, output logic [3:0] cin_seq);
        int waited;
        a_seq   = '0;
        cin_seq = '0;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_ready_timeout"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_a = 16'hDEAD; in_b = 16'hBEEF; in_cin = ~cin;
        for (int s = 0; s < 4; s++) begin
            a_seq   = {a_seq[11:0], add_a};
            cin_seq = {cin_seq[2:0], add_cin};
            if (out_valid) check({tag, "_early_valid"}, 32'd1, 32'd0);
            tick();
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_sum"}, {16'b0, out_sum}, {16'b0, exp_sum});
        check({tag, "_cout"}, {31'b0, out_cout}, {31'b0, exp_cout});
        tick();
        check({tag, "_idle_after"}, {30'b0, in_ready, out_valid}, 32'b10);
    endtask

    logic [15:0] seq_a;
    logic [3:0]  seq_c;
    logic [15:0] held_sum;
    logic [15:0] bb_a   [3] = '{16'h1234, 16'h8000, 16'h7FFF};
    logic [15:0] bb_b   [3] = '{16'h0FED, 16'h8000, 16'h0001};
    logic        bb_c   [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] bb_sum [3] = '{16'h2222, 16'h0000, 16'h8001};
    logic        bb_co  [3] = '{1'b0, 1'b1, 1'b0};
    int acc_cyc [3];
    int nacc, nres;
    logic take;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        tick();
        check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_state", {add_a, add_b, add_cin, in_ready, out_valid, out_cout}, 32'h04);
        check("rst_out_sum", {16'b0, out_sum}, 32'h0);

        // Basic add, slices presented LSB first.
        run_add("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, seq_a, seq_c);
        check("basic_add_a_seq", {16'b0, seq_a}, 32'h4321);

        // Carry ripples through every slice.
        run_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, seq_a, seq_c);
        check("ripple_cin_seq", {28'b0, seq_c}, 32'b0111);

        run_add("cin1", 16'h9ABC, 16'h6544, 1'b1, 16'h0001, 1'b1, seq_a, seq_c);
        run_add("cin0s", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, seq_a, seq_c);

        // Backpressure in DONE with new operands waiting.
        out_ready = 1'b0;
        in_a = 16'h0101; in_b = 16'h0202; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
        for (int s = 0; s < 4; s++) tick();
        held_sum = out_sum;
        check("bp_first_sum", {16'b0, held_sum}, 32'h0303);
        for (int s = 0; s < 3; s++) begin
            check("bp_hold", {13'b0, out_valid, in_ready, out_cout, out_sum}, {13'b0, 3'b100, 16'h0303});
            tick();
        end
        out_ready = 1'b1;
        check("bp_no_ready_on_hs", {31'b0, in_ready}, 32'd0);
        tick();
        check("bp_idle", {30'b0, in_ready, out_valid}, 32'b10);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", {31'b0, in_ready}, 32'd0);
        for (int s = 0; s < 4; s++) tick();
        check("bp_second", {15'b0, out_valid, out_cout, out_sum}, {15'b0, 2'b10, 16'h3333});
        tick();

        // Reset during the second RUN cycle discards the add.
        in_a = 16'h5555; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_state", {add_a, add_b, add_cin, in_ready, out_valid}, 32'h02);
        for (int s = 0; s < 6; s++) begin
            if (out_valid) check("mid_rst_emitted", 32'd1, 32'd0);
            tick();
        end
        run_add("post_rst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, seq_a, seq_c);

        // Back-to-back with in_valid held high.
        nacc = 0; nres = 0;
        in_a = bb_a[0]; in_b = bb_b[0]; in_cin = bb_c[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 80 && nres < 3; c++) begin
            take = in_valid && in_ready;
            if (take) acc_cyc[nacc] = c;
            if (out_valid && out_ready) begin
                check($sformatf("b2b_res%0d", nres), {15'b0, out_cout, out_sum}, {15'b0, bb_co[nres], bb_sum[nres]});
                nres++;
            end
            tick();
            if (take) begin
                nacc++;
                if (nacc < 3) begin
                    in_a = bb_a[nacc]; in_b = bb_b[nacc]; in_cin = bb_c[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_accepts", nacc, 32'd3);
        check("b2b_results", nres, 32'd3);
        if (nacc == 3) begin
            check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 32'd6);
            check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 32'd6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
